memoryaccess_lsu: RTL and testbench

//  Parametrised MemoryAccess stage (load/store unit) for the multicycle RV32I core.

---
 rtl/memoryaccess_lsu_pkg.sv | 36 +++
 rtl/memoryaccess_lsu_if.sv | 26 ++
 rtl/lsu_lane_align.sv | 65 ++++++
 rtl/memoryaccess_lsu.sv | 184 ++++++++++++++++++
 tb/tb_memoryaccess_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memoryaccess_lsu_pkg.sv
// memoryaccess_lsu_pkg: opcode field positions, FUNCT3 codes and FSM
// states shared by the MemoryAccess stage files.
package memoryaccess_lsu_pkg;

  localparam int FUNCT3_BIT_L = 0;
  localparam int FUNCT3_BIT_M = 2;
  localparam int DATA_MEM_WE  = 3;
  localparam int DATA_MEM_RE  = 4;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Halfwords need an even offset; words (and unknown sizes) need zero.
  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic r;
    r = |off;
    if (f3 == FUNCT3_B || f3 == FUNCT3_BU)
      r = 1'b0;
    else if (f3 == FUNCT3_H || f3 == FUNCT3_HU)
      r = off[0];
    return r;
  endfunction

endpackage

// File: rtl/memoryaccess_lsu_if.sv
// memoryaccess_lsu_if: req/ack bus between the MemoryAccess stage
// and DataMemory.
interface memoryaccess_lsu_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 14
);
  logic                dmem_req;
  logic                dmem_we;
  logic [AWIDTH-1:0]   dmem_addr;
  logic [XLEN/8-1:0]   dmem_be;
  logic [XLEN-1:0]     dmem_wdata;
  logic [XLEN-1:0]     dmem_rdata;
  logic                dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane enables/replication and load
// shift plus sign/zero extension, all combinational.
module lsu_lane_align
  import memoryaccess_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic [XLEN-1:0]   i_rs2,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN/8-1:0] o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_load
);
  localparam int NB = XLEN / 8;

  logic            w_byte;
  logic            w_half;
  logic            w_sgn;
  logic [1:0]      w_sh;
  logic [XLEN-1:0] w_shifted;

  assign w_byte = (i_funct3 == FUNCT3_B)
               || (i_funct3 == FUNCT3_BU);
  assign w_half = (i_funct3 == FUNCT3_H)
               || (i_funct3 == FUNCT3_HU);
  assign w_sgn  = (i_funct3 == FUNCT3_B)
               || (i_funct3 == FUNCT3_H);

  // Store side: lane select and data replication; unknown sizes act as W
  always_comb begin
    w_sh    = 2'd0;
    o_be    = '1;
    o_wdata = i_rs2;
    unique case (1'b1)
      w_byte: begin
        w_sh    = i_off;
        o_be    = NB'(1) << i_off;
        o_wdata = {NB{i_rs2[7:0]}};
      end
      w_half: begin
        w_sh    = {i_off[1], 1'b0};
        o_be    = NB'(3) << {i_off[1], 1'b0};
        o_wdata = {(NB/2){i_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = i_rdata >> {w_sh, 3'b000};

  // Load side: extend the shifted byte/halfword to XLEN
  always_comb begin
    o_load = w_shifted;
    unique case (1'b1)
      w_byte: o_load = {{(XLEN-8){w_sgn & w_shifted[7]}},
                        w_shifted[7:0]};
      w_half: o_load = {{(XLEN-16){w_sgn & w_shifted[15]}},
                        w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/memoryaccess_lsu.sv
// memoryaccess_lsu: MemoryAccess stage, req/ack DataMemory access with timeout.
// Optional feature: MISALIGN_TRAP_EN traps misaligned H/W accesses.
module memoryaccess_lsu
  import memoryaccess_lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AWIDTH   = 14,
  parameter int OPLEN    = 9,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_phase_memoryaccess,
  input  logic [OPLEN-1:0]  i_decoded_op_em,
  input  logic              i_jump_state_em,
  input  logic [4:0]        i_rdsel_em,
  input  logic [XLEN-1:0]   i_next_pc_em,
  input  logic [XLEN-1:0]   i_alu_out_em,
  input  logic [XLEN-1:0]   i_rs2data_em,
  memoryaccess_lsu_if.master dmem,
  output logic [OPLEN-1:0]  o_decoded_op_mw,
  output logic              o_jump_state_mw,
  output logic [4:0]        o_rdsel_mw,
  output logic [XLEN-1:0]   o_next_pc_mw,
  output logic [XLEN-1:0]   o_alu_out_mw,
  output logic [XLEN-1:0]   o_mem_out_mw,
  output logic              o_bus_err_mw,
  output logic              o_misalign_mw,
  output logic              o_stall_memoryaccess
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  lsu_state_e       r_state;
  lsu_state_e       w_next;
  logic [CW-1:0]    r_cnt;
  logic [OPLEN-1:0] r_op;
  logic             r_jump;
  logic [4:0]       r_rdsel;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_alu;
  logic [XLEN-1:0]  r_rs2;
  logic [XLEN-1:0]  r_mem;
  logic             r_berr;
  logic             r_mis;

  logic             w_memop_em;
  logic             w_mis_em;
  logic             w_stall;
  logic             w_latch;
  logic             w_ack;
  logic             w_tmo;
  logic [XLEN/8-1:0] w_be;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_load;

  assign w_memop_em = i_decoded_op_em[DATA_MEM_WE]
                    | i_decoded_op_em[DATA_MEM_RE];

`ifdef MISALIGN_TRAP_EN
  assign w_mis_em = w_memop_em && is_misaligned(
    i_decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L],
    i_alu_out_em[1:0]);
`else
  assign w_mis_em = 1'b0;
`endif

  // Next state, stall and capture strobes
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_latch = 1'b0;
    w_ack   = 1'b0;
    w_tmo   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_phase_memoryaccess) begin
          w_latch = 1'b1;
          w_next  = ST_DONE;
          if (w_memop_em) begin
            w_stall = 1'b1;
            if (!w_mis_em)
              w_next = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (dmem.dmem_ack) begin
          w_ack  = 1'b1;
          w_next = ST_DONE;
        end else if (r_cnt == CW'(MAX_WAIT)) begin
          w_tmo  = 1'b1;
          w_next = ST_DONE;
        end else begin
          w_stall = 1'b1;
        end
      end
      ST_DONE: begin
        if (!i_phase_memoryaccess)
          w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Wait-state counter, restarted on every new instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_latch)
      r_cnt <= '0;
    else if (r_state == ST_ACCESS)
      r_cnt <= r_cnt + 1'b1;
  end

  // Execute-to-WriteBack copies plus access operands held for the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_jump  <= 1'b0;
      r_rdsel <= '0;
      r_pc    <= '0;
      r_alu   <= '0;
      r_rs2   <= '0;
      r_berr  <= 1'b0;
      r_mis   <= 1'b0;
    end else if (w_latch) begin
      r_op    <= i_decoded_op_em;
      r_jump  <= i_jump_state_em;
      r_rdsel <= i_rdsel_em;
      r_pc    <= i_next_pc_em;
      r_alu   <= i_alu_out_em;
      r_rs2   <= i_rs2data_em;
      r_berr  <= 1'b0;
      r_mis   <= w_mis_em;
    end else if (w_tmo) begin
      r_berr  <= 1'b1;
    end
  end

  // Load result capture; a timeout forces it to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mem <= '0;
    else if (w_tmo)
      r_mem <= '0;
    else if (w_ack && !r_op[DATA_MEM_WE])
      r_mem <= w_load;
  end

  lsu_lane_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_funct3 (r_op[FUNCT3_BIT_M:FUNCT3_BIT_L]),
    .i_off    (r_alu[1:0]),
    .i_rs2    (r_rs2),
    .i_rdata  (dmem.dmem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_load   (w_load)
  );

  assign dmem.dmem_req   = (r_state == ST_ACCESS);
  assign dmem.dmem_we    = r_op[DATA_MEM_WE];
  assign dmem.dmem_addr  = {r_alu[AWIDTH-1:2], 2'b00};
  assign dmem.dmem_be    = w_be;
  assign dmem.dmem_wdata = w_wdata;

  assign o_decoded_op_mw      = r_op;
  assign o_jump_state_mw      = r_jump;
  assign o_rdsel_mw           = r_rdsel;
  assign o_next_pc_mw         = r_pc;
  assign o_alu_out_mw         = r_alu;
  assign o_mem_out_mw         = r_mem;
  assign o_bus_err_mw         = r_berr;
  assign o_misalign_mw        = r_mis;
  assign o_stall_memoryaccess = w_stall;

endmodule

// File: tb/tb_memoryaccess_lsu.sv
// tb_memoryaccess_lsu: directed and random MemoryAccess transactions
// checked against a size/offset arithmetic model of loads and stores.
module tb_memoryaccess_lsu;
  import memoryaccess_lsu_pkg::*;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phase;
  logic [8:0]  op_em;
  logic        jump_em;
  logic [4:0]  rd_em;
  logic [31:0] pc_em;
  logic [31:0] alu_em;
  logic [31:0] rs2_em;
  logic [8:0]  op_mw;
  logic        jump_mw;
  logic [4:0]  rd_mw;
  logic [31:0] pc_mw;
  logic [31:0] alu_mw;
  logic [31:0] mem_mw;
  logic        berr_mw;
  logic        mis_mw;
  logic        stall;

  int total = 0;
  int bad   = 0;

  logic [3:0]  o_be_first;
  logic [31:0] o_wd_first;
  logic [13:0] o_addr_first;
  int          o_nstall;
  int          o_nreq;

  always #5 clk = ~clk;

  memoryaccess_lsu_if #(.XLEN(32), .AWIDTH(14)) dmem();

  memoryaccess_lsu #(
    .XLEN(32), .AWIDTH(14), .OPLEN(9), .MAX_WAIT(15)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_phase_memoryaccess (phase),
    .i_decoded_op_em      (op_em),
    .i_jump_state_em      (jump_em),
    .i_rdsel_em           (rd_em),
    .i_next_pc_em         (pc_em),
    .i_alu_out_em         (alu_em),
    .i_rs2data_em         (rs2_em),
    .dmem                 (dmem),
    .o_decoded_op_mw      (op_mw),
    .o_jump_state_mw      (jump_mw),
    .o_rdsel_mw           (rd_mw),
    .o_next_pc_mw         (pc_mw),
    .o_alu_out_mw         (alu_mw),
    .o_mem_out_mw         (mem_mw),
    .o_bus_err_mw         (berr_mw),
    .o_misalign_mw        (mis_mw),
    .o_stall_memoryaccess (stall)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                     input logic [1:0] off);
    int sz;
    sz = m_size(f3);
    if (sz == 1) return 4'(1 << off);
    if (sz == 2) return 4'(3 << (off & 2'd2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                         input logic [31:0] rs2);
    int sz;
    sz = m_size(f3);
    if (sz == 1) return 32'(rs2[7:0]) * 32'h0101_0101;
    if (sz == 2) return 32'(rs2[15:0]) * 32'h0001_0001;
    return rs2;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                        input logic [1:0] off,
                                        input logic [31:0] rdata);
    int sz;
    int sh;
    logic [31:0] v;
    logic [31:0] mask;
    sz = m_size(f3);
    sh = (sz == 1) ? int'(off) : (sz == 2) ? int'(off & 2'd2) : 0;
    v = rdata >> (8 * sh);
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1])
      v = v | ~mask;
    return v;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3,
                               input logic [1:0] off);
    int sz;
    sz = m_size(f3);
    if (sz == 2) return off[0];
    if (sz == 4) return off != 2'd0;
    return 1'b0;
  endfunction

  // waits < 0 means the memory never acknowledges.
  task automatic run_op(input logic        we,
                        input logic        re,
                        input logic [2:0]  f3,
                        input logic [31:0] alu,
                        input logic [31:0] rs2,
                        input logic [31:0] rdat,
                        input int          waits,
                        input logic        jmp,
                        input logic [4:0]  rd,
                        input logic [31:0] pc);
    logic [8:0] op;
    bit memop, mis, iss, tmo, done;
    int exp_req, exp_st, nst, nrq;
    op = {4'($urandom), re, we, f3};
    memop = we | re;
    mis = TRAP && memop && m_mis(f3, alu[1:0]);
    iss = memop && !mis;
    tmo = iss && (waits < 0 || waits > 15);
    exp_req = !iss ? 0 : tmo ? 16 : waits + 1;
    exp_st = !memop ? 0 : !iss ? 1 : tmo ? 16 : waits + 1;
    o_be_first = '0;
    o_wd_first = '0;
    o_addr_first = '0;
    @(negedge clk);
    op_em = op;
    jump_em = jmp;
    rd_em = rd;
    pc_em = pc;
    alu_em = alu;
    rs2_em = rs2;
    phase = 1'b1;
    dmem.dmem_ack = 1'b0;
    nst = 0;
    nrq = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (dmem.dmem_req) begin
        check("we", dmem.dmem_we, we);
        check("addr", dmem.dmem_addr, alu[13:0] & 14'h3FFC);
        check("be", dmem.dmem_be, m_be(f3, alu[1:0]));
        if (we)
          check("wdata", dmem.dmem_wdata, m_wdata(f3, rs2));
        if (nrq == 0) begin
          o_be_first = dmem.dmem_be;
          o_wd_first = dmem.dmem_wdata;
          o_addr_first = dmem.dmem_addr;
        end
        dmem.dmem_ack = (waits >= 0 && nrq == waits);
        dmem.dmem_rdata = dmem.dmem_ack ? rdat : $urandom;
        nrq++;
      end else begin
        dmem.dmem_ack = 1'b0;
      end
      #1;
      if (stall) nst++;
      else done = 1'b1;
      @(negedge clk);
      op_em = 9'($urandom);
      alu_em = $urandom;
      rs2_em = $urandom;
      pc_em = $urandom;
      rd_em = 5'($urandom);
    end
    check("finished", done, 1'b1);
    phase = 1'b0;
    dmem.dmem_ack = 1'b0;
    #1;
    o_nstall = nst;
    o_nreq = nrq;
    check("stall_cycles", nst, exp_st);
    check("req_cycles", nrq, exp_req);
    check("bus_err", berr_mw, tmo);
    check("misalign", mis_mw, mis);
    check("op_mw", op_mw, op);
    check("jump_mw", jump_mw, jmp);
    check("rdsel_mw", rd_mw, rd);
    check("pc_mw", pc_mw, pc);
    check("alu_mw", alu_mw, alu);
    if (iss && (tmo || !we))
      check("mem_out", mem_mw, tmo ? 32'd0 : m_load(f3, alu[1:0], rdat));
  endtask

  initial begin
    phase = 1'b0;
    op_em = '0;
    jump_em = 1'b0;
    rd_em = '0;
    pc_em = '0;
    alu_em = '0;
    rs2_em = '0;
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req", dmem.dmem_req, 1'b0);
    check("rst_we", dmem.dmem_we, 1'b0);
    check("rst_addr", dmem.dmem_addr, 14'd0);
    check("rst_op", op_mw, 9'd0);
    check("rst_pc", pc_mw, 32'd0);
    check("rst_alu", alu_mw, 32'd0);
    check("rst_mem", mem_mw, 32'd0);
    check("rst_berr", berr_mw, 1'b0);
    check("rst_mis", mis_mw, 1'b0);
    check("rst_stall", stall, 1'b0);
    rst_n = 1'b1;

    // SB, zero wait states
    run_op(1'b1, 1'b0, FUNCT3_B, 32'h103, 32'hA5,
           32'h0, 0, 1'b0, 5'd1, 32'h10);
    check("t1_be", o_be_first, 4'b1000);
    check("t1_wdata", o_wd_first, 32'hA5A5A5A5);
    check("t1_stall", o_nstall, 1);

    // LH, three wait states
    run_op(1'b0, 1'b1, FUNCT3_H, 32'h102, 32'h0,
           32'h8001_1234, 3, 1'b0, 5'd2, 32'h14);
    check("t2_mem", mem_mw, 32'hFFFF8001);
    check("t2_stall", o_nstall, 4);

    // LBU offset 1, then aligned LW
    run_op(1'b0, 1'b1, FUNCT3_BU, 32'h101, 32'h0,
           32'h0000_AA00, 1, 1'b1, 5'd3, 32'h18);
    check("t3_lbu", mem_mw, 32'h0000_00AA);
    run_op(1'b0, 1'b1, FUNCT3_W, 32'h100, 32'h0,
           32'h5555_5555, 2, 1'b0, 5'd4, 32'h1C);
    check("t3_lw", mem_mw, 32'h5555_5555);

    // No acknowledge at all
    run_op(1'b0, 1'b1, FUNCT3_W, 32'h104, 32'h0,
           32'h1234_5678, -1, 1'b0, 5'd5, 32'h20);
    check("t4_req", o_nreq, 16);
    check("t4_berr", berr_mw, 1'b1);
    check("t4_mem", mem_mw, 32'd0);

    // LW at a misaligned address
    run_op(1'b0, 1'b1, FUNCT3_W, 32'h102, 32'h0,
           32'h1122_3344, 0, 1'b0, 5'd6, 32'h24);
`ifdef MISALIGN_TRAP_EN
    check("t5_req", o_nreq, 0);
    check("t5_mis", mis_mw, 1'b1);
`else
    check("t5_req", o_nreq, 1);
    check("t5_be", o_be_first, 4'hF);
    check("t5_addr", o_addr_first, 14'h100);
    check("t5_mis", mis_mw, 1'b0);
`endif

    // Reset in the middle of an access
    @(negedge clk);
    op_em = 9'h010;
    alu_em = 32'h200;
    rd_em = 5'd9;
    pc_em = 32'h44;
    jump_em = 1'b1;
    phase = 1'b1;
    dmem.dmem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t6_req_before", dmem.dmem_req, 1'b1);
    rst_n = 1'b0;
    phase = 1'b0;
    #1;
    check("t6_req", dmem.dmem_req, 1'b0);
    check("t6_op", op_mw, 9'd0);
    check("t6_rd", rd_mw, 5'd0);
    check("t6_pc", pc_mw, 32'd0);
    check("t6_jump", jump_mw, 1'b0);
    check("t6_alu", alu_mw, 32'd0);
    check("t6_mem", mem_mw, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 1'b0, 3'd0, 32'h77, 32'h0,
           32'h0, 0, 1'b1, 5'd7, 32'h400);
    check("t6_alu_stall", o_nstall, 0);
    check("t6_alu_pc", pc_mw, 32'h400);
    check("t6_alu_rd", rd_mw, 5'd7);

    // Random mix of loads, stores, ALU ops and timeouts
    for (int n = 0; n < 40; n++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      run_op(1'($urandom), 1'($urandom), 3'($urandom),
             $urandom, $urandom, $urandom, w,
             1'($urandom), 5'($urandom), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
